// File: rtl/tetris_board_buffer.sv
// Double-buffered Tetris play-field bitmap with a frame-synchronous bank swap,
// a registered pixel-occupancy lookup for the display, and a back-bank read port.
module tetris_board_buffer #(
  parameter int ROWS       = 10,
  parameter int COLS       = 20,
  parameter int CELL_SHIFT = 4,
  parameter int X0         = 16,
  parameter int Y0         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     active_x,
  input  logic [11:0]     active_y,
  output logic            temp_bit,
  input  logic            frame_start,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [3:0]      wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            commit,
  input  logic [3:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            commit_done,
  output logic            busy
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = $clog2(ROWS + 1);

  localparam logic [3:0]       ROWS_4   = 4'(ROWS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS);
  localparam logic [11:0]      X_LO     = 12'(X0);
  localparam logic [11:0]      X_HI     = 12'(X0 + (COLS << CELL_SHIFT));
  localparam logic [11:0]      Y_LO     = 12'(Y0);
  localparam logic [11:0]      Y_HI     = 12'(Y0 + (ROWS << CELL_SHIFT));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    COPY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [COLS-1:0]  r_bank0 [ROWS];
  logic [COLS-1:0]  r_bank1 [ROWS];
  logic             r_front_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_temp_bit;
  logic [COLS-1:0]  r_rd_data;
  logic             r_commit_done;

  logic             w_wr_en;
  logic             w_copy_en;
  logic             w_swap;
  logic             w_done;
  logic             w_wr_ready;
  logic             w_busy;

  logic [ROW_W-1:0] w_wr_idx;
  logic [ROW_W-1:0] w_cnt_idx;
  logic [ROW_W-1:0] w_rd_idx;
  logic [ROW_W-1:0] w_pix_row;
  logic [COL_W-1:0] w_pix_col;
  logic             w_in_win;
  logic             w_rd_in_range;
  logic [COLS-1:0]  w_front_pix;
  logic [COLS-1:0]  w_back_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // COPY lingers one extra cycle at cnt==ROWS so commit_done lands ROWS+1 cycles after the swap.
  always_comb begin
    w_next     = r_state;
    w_wr_ready = 1'b0;
    w_busy     = 1'b0;
    w_wr_en    = 1'b0;
    w_copy_en  = 1'b0;
    w_swap     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_ready = 1'b1;
        w_wr_en    = wr_valid && (wr_row < ROWS_4);
        if (commit) begin
          w_next = PEND;
        end
      end
      PEND: begin
        w_busy = 1'b1;
        if (frame_start) begin
          w_swap = 1'b1;
          w_next = COPY;
        end
      end
      COPY: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else begin
          w_copy_en = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_wr_idx      = ROW_W'(wr_row);
  assign w_cnt_idx     = ROW_W'(r_cnt);
  assign w_rd_in_range = (rd_row < ROWS_4);
  assign w_rd_idx      = w_rd_in_range ? ROW_W'(rd_row) : '0;

  assign w_in_win  = (active_x >= X_LO) && (active_x < X_HI) &&
                     (active_y >= Y_LO) && (active_y < Y_HI);
  assign w_pix_col = w_in_win ? COL_W'((active_x - X_LO) >> CELL_SHIFT) : '0;
  assign w_pix_row = w_in_win ? ROW_W'((active_y - Y_LO) >> CELL_SHIFT) : '0;

  assign w_front_pix = r_front_sel ? r_bank1[w_pix_row] : r_bank0[w_pix_row];
  assign w_back_rd   = r_front_sel ? r_bank0[w_rd_idx]  : r_bank1[w_rd_idx];

  // front_sel=0 shows bank0 and leaves bank1 as the back bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
      r_front_sel <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_wr_en) begin
        if (r_front_sel) begin
          r_bank0[w_wr_idx] <= wr_data;
        end else begin
          r_bank1[w_wr_idx] <= wr_data;
        end
      end
      if (w_copy_en) begin
        if (r_front_sel) begin
          r_bank0[w_cnt_idx] <= r_bank1[w_cnt_idx];
        end else begin
          r_bank1[w_cnt_idx] <= r_bank0[w_cnt_idx];
        end
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_swap) begin
        r_front_sel <= ~r_front_sel;
        r_cnt       <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_temp_bit    <= 1'b0;
      r_rd_data     <= '0;
      r_commit_done <= 1'b0;
    end else begin
      r_temp_bit    <= w_in_win & w_front_pix[w_pix_col];
      r_rd_data     <= w_rd_in_range ? w_back_rd : '0;
      r_commit_done <= w_done;
    end
  end

  assign temp_bit    = r_temp_bit;
  assign rd_data     = r_rd_data;
  assign commit_done = r_commit_done;
  assign wr_ready    = w_wr_ready;
  assign busy        = w_busy;

endmodule

// File: tb/tb_tetris_board_buffer.sv
// Directed self-checking bench for tetris_board_buffer: reset, swap timing,
// pixel window edges, copy-back, dropped writes/commits and mid-copy reset.
module tb_tetris_board_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] active_x;
  logic [11:0] active_y;
  logic        temp_bit;
  logic        frame_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_row;
  logic [19:0] wr_data;
  logic        commit;
  logic [3:0]  rd_row;
  logic [19:0] rd_data;
  logic        commit_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tetris_board_buffer dut (
    .clk(clk), .rst(rst), .active_x(active_x), .active_y(active_y),
    .temp_bit(temp_bit), .frame_start(frame_start), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data), .commit(commit),
    .rd_row(rd_row), .rd_data(rd_data), .commit_done(commit_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int x, input int y, output logic b);
    active_x = 12'(x);
    active_y = 12'(y);
    tick();
    b = temp_bit;
  endtask

  task automatic read_row(input int r, output logic [19:0] d);
    rd_row = 4'(r);
    tick();
    d = rd_data;
  endtask

  task automatic write_row(input int r, input logic [19:0] d);
    wr_valid = 1'b1;
    wr_row   = 4'(r);
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Counts cycles until commit_done (cap 40); flags any cycle where busy dropped early.
  task automatic wait_done(output int n, output logic busy_dropped);
    n = 0;
    busy_dropped = 1'b0;
    do begin
      tick();
      n++;
      if (!commit_done && !busy) busy_dropped = 1'b1;
    end while (!commit_done && n < 40);
  endtask

  task automatic test_reset();
    int ones;
    logic b;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready got %b expected 1", wr_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++;
    if (commit_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_done got %b expected 0", commit_done); end
    ones = 0;
    for (int y = 0; y < 272; y += 9) begin
      for (int x = 0; x < 480; x++) begin
        lookup(x, y, b);
        if (b !== 1'b0) ones++;
      end
    end
    lookup(479, 271, b);
    if (b !== 1'b0) ones++;
    checks++;
    if (ones !== 0) begin errors++; $display("[TB] FAIL reset_sweep got %0d set pixels expected 0", ones); end
  endtask

  task automatic test_commit_row0();
    int n;
    logic dropped;
    logic b;
    write_row(0, 20'h00001);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_busy got busy=%b wr_ready=%b expected 1/0", busy, wr_ready); end
    repeat (4) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(n, dropped);
    checks++;
    if (n !== 11) begin errors++; $display("[TB] FAIL done_latency got %0d expected 11", n); end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("[TB] FAIL busy_during_swap got dropped=%b expected 0", dropped); end
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL done_idle got wr_ready=%b busy=%b expected 1/0", wr_ready, busy); end
    tick();
    checks++;
    if (commit_done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width got %b expected 0", commit_done); end
    lookup(16, 16, b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("[TB] FAIL pix_16_16 got %b expected 1", b); end
    lookup(32, 16, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL pix_32_16 got %b expected 0", b); end
    lookup(15, 16, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL pix_15_16 got %b expected 0", b); end
    lookup(16, 32, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL pix_16_32 got %b expected 0", b); end
  endtask

  task automatic test_no_commit();
    int n;
    logic dropped;
    logic b;
    write_row(9, 20'h80000);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_frame_busy got %b expected 0", busy); end
    lookup(335, 175, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL no_commit_pix got %b expected 0", b); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(n, dropped);
    checks++;
    if (n !== 11) begin errors++; $display("[TB] FAIL done_latency2 got %0d expected 11", n); end
    lookup(335, 175, b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("[TB] FAIL pix_335_175 got %b expected 1", b); end
    lookup(336, 175, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL pix_336_175 got %b expected 0", b); end
    lookup(335, 176, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL pix_335_176 got %b expected 0", b); end
  endtask

  task automatic test_copy_back();
    logic [19:0] d;
    logic b;
    read_row(9, d);
    checks++;
    if (d !== 20'h80000) begin errors++; $display("[TB] FAIL copy_back_row9 got %h expected 80000", d); end
    rd_row   = 4'd3;
    wr_valid = 1'b1;
    wr_row   = 4'd3;
    wr_data  = 20'h0F0F0;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (rd_data !== 20'h00000) begin errors++; $display("[TB] FAIL rd_same_cycle got %h expected 00000", rd_data); end
    tick();
    checks++;
    if (rd_data !== 20'h0F0F0) begin errors++; $display("[TB] FAIL rd_next_cycle got %h expected 0f0f0", rd_data); end
    lookup(80, 64, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL pix_80_64_before got %b expected 0", b); end
  endtask

  task automatic test_commit_frame_same();
    int n;
    logic dropped;
    logic b;
    logic [19:0] d;
    logic [19:0] exp_rows [10];
    commit      = 1'b1;
    frame_start = 1'b1;
    tick();
    commit      = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_pend got busy=%b expected 1", busy); end
    wr_valid = 1'b1;
    wr_row   = 4'd5;
    wr_data  = 20'hFFFFF;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_wr_ready got %b expected 0", wr_ready); end
    tick();
    wr_valid = 1'b0;
    read_row(5, d);
    checks++;
    if (d !== 20'h00000) begin errors++; $display("[TB] FAIL pend_write_dropped got %h expected 00000", d); end
    lookup(80, 64, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL no_swap_same_cycle got %b expected 0", b); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(n, dropped);
    checks++;
    if (n !== 11) begin errors++; $display("[TB] FAIL done_latency3 got %0d expected 11", n); end
    lookup(80, 64, b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("[TB] FAIL pix_80_64_after got %b expected 1", b); end
    lookup(16, 96, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL pix_row5 got %b expected 0", b); end
    write_row(12, 20'hFFFFF);
    exp_rows = '{20'h00001, 20'h0, 20'h0, 20'h0F0F0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0, 20'h80000};
    for (int r = 0; r < 10; r++) begin
      read_row(r, d);
      checks++;
      if (d !== exp_rows[r]) begin errors++; $display("[TB] FAIL row%0d_after_oob got %h expected %h", r, d, exp_rows[r]); end
    end
    read_row(12, d);
    checks++;
    if (d !== 20'h00000) begin errors++; $display("[TB] FAIL rd_row12 got %h expected 00000", d); end
  endtask

  task automatic test_reset_mid_copy();
    int n;
    logic dropped;
    logic b;
    logic [19:0] d;
    write_row(1, 20'hFFFFF);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_copy_reset_state got busy=%b wr_ready=%b expected 0/1", busy, wr_ready); end
    checks++;
    if (temp_bit !== 1'b0 || rd_data !== 20'h0) begin errors++; $display("[TB] FAIL mid_copy_reset_outs got temp=%b rd=%h expected 0/00000", temp_bit, rd_data); end
    wait_done(n, dropped);
    checks++;
    if (n !== 40) begin errors++; $display("[TB] FAIL no_done_after_reset got done at %0d expected none", n); end
    lookup(16, 16, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_16_16 got %b expected 0", b); end
    lookup(80, 64, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_80_64 got %b expected 0", b); end
    lookup(335, 175, b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_335_175 got %b expected 0", b); end
    for (int r = 0; r < 10; r++) begin
      read_row(r, d);
      checks++;
      if (d !== 20'h0) begin errors++; $display("[TB] FAIL reset_back_row%0d got %h expected 00000", r, d); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    active_x    = '0;
    active_y    = '0;
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    wr_row      = '0;
    wr_data     = '0;
    commit      = 1'b0;
    rd_row      = '0;
    $display("[TB] starting tetris_board_buffer bench");
    test_reset();
    test_commit_row0();
    test_no_commit();
    test_copy_back();
    test_commit_frame_same();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
